// File: rtl/flag_cond_unit_if.sv
// Execute-stage bundle between the pipeline control and the flag/condition unit.
// The unit is the slave; the pipeline drives E-stage inputs and consumes M outputs.
interface flag_cond_unit_if;
    logic [3:0]  ALUFlags;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic        ValidE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        PCSrcE;
    logic        BranchE;
    logic        Stall;
    logic        FlushE;
    logic [3:0]  FlagsQ;
    logic        CondExE;
    logic        BranchTakenE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        PCSrcM;
    logic [15:0] BranchCount;

    modport master (
        output ALUFlags, CondE, FlagWriteE, ValidE, RegWriteE, MemWriteE,
               PCSrcE, BranchE, Stall, FlushE,
        input  FlagsQ, CondExE, BranchTakenE, RegWriteM, MemWriteM, PCSrcM,
               BranchCount
    );
    modport slave (
        input  ALUFlags, CondE, FlagWriteE, ValidE, RegWriteE, MemWriteE,
               PCSrcE, BranchE, Stall, FlushE,
        output FlagsQ, CondExE, BranchTakenE, RegWriteM, MemWriteM, PCSrcM,
               BranchCount
    );
endinterface

// File: rtl/flag_cond_unit.sv
// Architectural flag register, condition check and E->M control gating,
// plus a saturating counter of taken branches.
module flag_cond_unit (
    input logic             clk,
    input logic             reset,
    flag_cond_unit_if.slave bus
);
    logic [3:0]  flags_q;
    logic        cond_ex;
    logic        go;
    logic        reg_write_m;
    logic        mem_write_m;
    logic        pc_src_m;
    logic [15:0] branch_count;

    logic n, z, c, v;
    assign {n, z, c, v} = flags_q;

    // Condition is evaluated against the registered flags only, so a flag
    // write lands for the following instruction with no bypass.
    always_comb begin
        cond_ex = 1'b1;
        case (bus.CondE)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign go = bus.ValidE & cond_ex & ~bus.FlushE & ~bus.Stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= 4'b0000;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            pc_src_m     <= 1'b0;
            branch_count <= 16'h0000;
        end else begin
            if (go && bus.FlagWriteE[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
            if (go && bus.FlagWriteE[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
            if (go && bus.BranchE && branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            // Flush beats stall so a killed instruction never leaks into M.
            if (bus.FlushE) begin
                reg_write_m <= 1'b0;
                mem_write_m <= 1'b0;
                pc_src_m    <= 1'b0;
            end else if (!bus.Stall) begin
                reg_write_m <= bus.RegWriteE & bus.ValidE & cond_ex;
                mem_write_m <= bus.MemWriteE & bus.ValidE & cond_ex;
                pc_src_m    <= bus.PCSrcE    & bus.ValidE & cond_ex;
            end
        end
    end

    assign bus.FlagsQ       = flags_q;
    assign bus.CondExE      = cond_ex;
    assign bus.BranchTakenE = bus.ValidE & ~bus.FlushE & cond_ex & (bus.BranchE | bus.PCSrcE);
    assign bus.RegWriteM    = reg_write_m;
    assign bus.MemWriteM    = mem_write_m;
    assign bus.PCSrcM       = pc_src_m;
    assign bus.BranchCount  = branch_count;
endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: reset, flag writes, condition sweep,
// stall/flush interaction, suppression and counter saturation.
module tb_flag_cond_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    flag_cond_unit_if bus ();

    flag_cond_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ALUFlags   = 4'h0;
        bus.CondE      = 4'hE;
        bus.FlagWriteE = 2'b00;
        bus.ValidE     = 1'b0;
        bus.RegWriteE  = 1'b0;
        bus.MemWriteE  = 1'b0;
        bus.PCSrcE     = 1'b0;
        bus.BranchE    = 1'b0;
        bus.Stall      = 1'b0;
        bus.FlushE     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m(input string tag, input logic [2:0] exp);
        chk(tag, {13'd0, bus.RegWriteM, bus.MemWriteM, bus.PCSrcM}, {13'd0, exp});
    endtask

    // Table expressed as even-code predicate, odd code = its inverse.
    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc & ~fz;
            3'd5: base = ~(fn ^ fv);
            3'd6: base = ~fz & ~(fn ^ fv);
            default: return 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic load_flags(input logic [3:0] f);
        idle();
        bus.ALUFlags = f; bus.FlagWriteE = 2'b11; bus.ValidE = 1'b1;
        step();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();

        // reset with random inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {bus.ALUFlags, bus.CondE} = 8'($urandom);
            {bus.FlagWriteE, bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.PCSrcE, bus.BranchE} = 7'($urandom);
            step();
        end
        chk("rst_flags", {12'd0, bus.FlagsQ}, 16'h0);
        chk_m("rst_m", 3'b000);
        chk("rst_cnt", bus.BranchCount, 16'h0);
        idle();
        reset = 1'b1;
        #1;
        bus.CondE = 4'b0000; #1;
        chk("rst_eq", {15'd0, bus.CondExE}, 16'd0);
        bus.CondE = 4'b0001; #1;
        chk("rst_ne", {15'd0, bus.CondExE}, 16'd1);
        step();
        chk("rst_hold", {12'd0, bus.FlagsQ}, 16'h0);

        // flag write, no same-cycle bypass
        bus.ALUFlags = 4'b0100; bus.CondE = 4'b0000; #1;
        chk("nobypass", {15'd0, bus.CondExE}, 16'd0);
        bus.CondE = 4'b1110; bus.FlagWriteE = 2'b11; bus.ValidE = 1'b1;
        step();
        chk("fw_flags", {12'd0, bus.FlagsQ}, 16'h4);
        idle();
        bus.CondE = 4'b0000; #1;
        chk("fw_eq", {15'd0, bus.CondExE}, 16'd1);

        // split writes
        load_flags(4'b1010);
        chk("split_pre", {12'd0, bus.FlagsQ}, 16'hA);
        bus.ALUFlags = 4'b0101; bus.FlagWriteE = 2'b01; bus.ValidE = 1'b1;
        step();
        chk("split_cv", {12'd0, bus.FlagsQ}, 16'h9);
        bus.ALUFlags = 4'b0110; bus.FlagWriteE = 2'b10;
        step();
        chk("split_nz", {12'd0, bus.FlagsQ}, 16'h5);

        // condition sweep
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                bus.CondE = 4'(c); bus.ValidE = 1'b1; bus.RegWriteE = 1'b1;
                #1;
                chk($sformatf("cond_f%0d_c%0d", f, c), {15'd0, bus.CondExE},
                    {15'd0, cond_model(4'(c), 4'(f))});
                step();
                chk($sformatf("rw_f%0d_c%0d", f, c), {15'd0, bus.RegWriteM},
                    {15'd0, cond_model(4'(c), 4'(f))});
            end
        end
        chk("sweep_cnt", bus.BranchCount, 16'h0);
        idle();
        step();
        chk("sweep_flags", {12'd0, bus.FlagsQ}, 16'hF);

        // taken branch stalled for 3 cycles
        bus.ValidE = 1'b1; bus.BranchE = 1'b1; bus.PCSrcE = 1'b1;
        bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0000; bus.Stall = 1'b1;
        #1;
        chk("stall_taken", {15'd0, bus.BranchTakenE}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_cnt%0d", i), bus.BranchCount, 16'h0);
            chk($sformatf("stall_pc%0d", i), {15'd0, bus.PCSrcM}, 16'd0);
            chk($sformatf("stall_fl%0d", i), {12'd0, bus.FlagsQ}, 16'hF);
        end
        bus.Stall = 1'b0;
        step();
        chk("rel_cnt", bus.BranchCount, 16'h1);
        chk("rel_pc", {15'd0, bus.PCSrcM}, 16'd1);
        chk("rel_fl", {12'd0, bus.FlagsQ}, 16'h0);
        idle();
        step();
        chk("post_cnt", bus.BranchCount, 16'h1);
        chk_m("post_m", 3'b000);

        // flush together with stall
        bus.ValidE = 1'b1; bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.PCSrcE = 1'b1;
        step();
        chk_m("pre_flush_m", 3'b111);
        bus.FlushE = 1'b1; bus.Stall = 1'b1; bus.BranchE = 1'b1;
        bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b1111;
        #1;
        chk("flush_taken", {15'd0, bus.BranchTakenE}, 16'd0);
        step();
        chk_m("flush_m", 3'b000);
        chk("flush_fl", {12'd0, bus.FlagsQ}, 16'h0);
        chk("flush_cnt", bus.BranchCount, 16'h1);

        // failed condition and bubble suppress everything
        bus.FlushE = 1'b0; bus.Stall = 1'b0; bus.CondE = 4'b0000;
        step();
        chk_m("fail_m", 3'b000);
        chk("fail_fl", {12'd0, bus.FlagsQ}, 16'h0);
        chk("fail_cnt", bus.BranchCount, 16'h1);
        bus.CondE = 4'b1110; bus.ValidE = 1'b0;
        #1;
        chk("bub_taken", {15'd0, bus.BranchTakenE}, 16'd0);
        step();
        chk_m("bub_m", 3'b000);
        chk("bub_fl", {12'd0, bus.FlagsQ}, 16'h0);
        chk("bub_cnt", bus.BranchCount, 16'h1);

        // saturation
        idle();
        bus.ValidE = 1'b1; bus.BranchE = 1'b1;
        for (int i = 0; i < 16'hFFFD; i++) @(posedge clk);
        #1;
        chk("sat_pre", bus.BranchCount, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sat%0d", i), bus.BranchCount, 16'hFFFF);
        end

        // async reset mid-stall/flush, then normal first edge
        bus.Stall = 1'b1; bus.FlushE = 1'b1; bus.RegWriteE = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cnt", bus.BranchCount, 16'h0);
        chk_m("arst_m", 3'b000);
        chk("arst_fl", {12'd0, bus.FlagsQ}, 16'h0);
        idle();
        bus.ValidE = 1'b1; bus.RegWriteE = 1'b1; bus.BranchE = 1'b1;
        reset = 1'b1;
        step();
        chk_m("first_m", 3'b100);
        chk("first_cnt", bus.BranchCount, 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flag_cond_unit.md
FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 ALUFlags  input  4  execute-stage ALU flags, {N,Z,C,V} = bits [3:0].
REQ-005 CondE  input  4  execute-stage instruction condition field.
REQ-006 FlagWriteE  input  2  [1] enables update of N,Z; [0] enables update of C,V.
REQ-007 ValidE  input  1  execute stage holds a real instruction (0 = bubble).
REQ-008 RegWriteE, MemWriteE, PCSrcE, BranchE  input  1 each  ungated execute-stage controls.
REQ-009 Stall  input  1  hold the E→M boundary this cycle.
REQ-010 FlushE  input  1  kill the instruction in execute this cycle.
REQ-011 FlagsQ  output  4  architectural flags {N,Z,C,V}, registered.
REQ-012 CondExE  output  1  combinational condition-pass for CondE against FlagsQ.
REQ-013 BranchTakenE  output  1  combinational: ValidE & ~FlushE & CondExE & (BranchE | PCSrcE).
REQ-014 RegWriteM, MemWriteM, PCSrcM  output  1 each  registered gated controls for the memory stage.
REQ-015 BranchCount  output  16  registered count of taken branches, saturating.

Function
REQ-016 CondExE SHALL decode CondE against FlagsQ (never against ALUFlags) as follows.
- 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
- 0100 N; 0101 ~N; 0110 V; 0111 ~V
- 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V
- 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1
REQ-017 Define Go = ValidE & CondExE & ~FlushE & ~Stall.
REQ-018 On a clk edge with Go & FlagWriteE[1], FlagsQ[3:2] SHALL load ALUFlags[3:2].
REQ-019 On a clk edge with Go & FlagWriteE[0], FlagsQ[1:0] SHALL load ALUFlags[1:0].
REQ-020 The two flag halves SHALL update independently; a disabled half SHALL hold its value.
REQ-021 A flag update SHALL become visible to CondExE in the next cycle only, with no same-cycle bypass.
REQ-022 The M register SHALL apply the following priority on each clk edge.
- FlushE: RegWriteM, MemWriteM and PCSrcM SHALL load 0, regardless of Stall.
- else Stall: RegWriteM, MemWriteM and PCSrcM SHALL hold.
- else: each SHALL load its E input & ValidE & CondExE.
REQ-023 Latency from E inputs to the gated M outputs SHALL be exactly 1 cycle.
REQ-024 BranchCount SHALL increment on a clk edge when Go & BranchE.
REQ-025 BranchCount SHALL saturate at 0xFFFF; an increment at 0xFFFF SHALL leave it unchanged.
REQ-026 While Stall=1, FlagsQ and BranchCount SHALL NOT change, so a stalled instruction is counted and flag-written exactly once.
REQ-027 When Stall and FlushE are both asserted, the block SHALL produce a bubble, no flag update and no count.
REQ-028 A failed condition SHALL suppress all side effects: flags, count and gated controls.
REQ-029 ValidE=0 SHALL suppress all side effects identically to a failed condition.

Reset
REQ-030 While reset=0, FlagsQ SHALL be 4'b0000, RegWriteM, MemWriteM and PCSrcM SHALL be 0, and BranchCount SHALL be 0, asynchronously to clk.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override every other input.
REQ-032 After reset releases, the first clk edge SHALL process E inputs normally.

Verification
REQ-033 Reset scenario: hold reset=0 with random inputs, then release → FlagsQ=0000, M outputs 0, BranchCount=0; CondE=0000 gives CondExE=0 and CondE=0001 gives CondExE=1.
REQ-034 Flag-write scenario: ALUFlags=0100, FlagWriteE=11, CondE=1110, ValidE=1, one edge → FlagsQ=0100; next cycle CondE=0000 gives CondExE=1.
REQ-035 Split-write scenario: FlagsQ=1010, ALUFlags=0101, FlagWriteE=01 → FlagsQ=1001.
REQ-036 Condition-table sweep scenario: for all 16 FlagsQ values × 16 CondE values, CondExE matches REQ-016; RegWriteE=1 yields RegWriteM=CondExE one cycle later.
REQ-037 Stall/flush scenario: taken branch with Stall=1 for 3 cycles, then 0 → BranchCount +1 exactly, with PCSrcM held during the stall; FlushE=1 together with Stall=1 → M outputs 0 and FlagsQ unchanged.
REQ-038 Saturation scenario: preload 0xFFFE, drive 3 consecutive taken branches → BranchCount reads 0xFFFF and stays there.
